// File: rtl/axis_packet_merger_if.sv
// AXI-Stream bundle shared by the packet merger's input and output sides.
interface axis_packet_merger_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned KEEP_WIDTH = 2,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_packet_merger.sv
// Gathers pckt_count input packets of pckt_size beats into one output packet,
// stripping inner tlast markers and flagging length mismatches.
module axis_packet_merger #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
  parameter bit          ID_ENABLE   = 1'b0,
  parameter int unsigned ID_WIDTH    = ID_ENABLE ? 8 : 1,
  parameter bit          DEST_ENABLE = 1'b0,
  parameter int unsigned DEST_WIDTH  = DEST_ENABLE ? 8 : 1,
  parameter bit          USER_ENABLE = 1'b0,
  parameter int unsigned USER_WIDTH  = USER_ENABLE ? 8 : 1,
  parameter int unsigned PCKT_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter bit          ALLOW_LOCKS = 1'b1,
  parameter bit          CHECK_TLAST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  operation_start,
  input  logic [PCKT_WIDTH-1:0] pckt_size,
  input  logic [CNT_WIDTH-1:0]  pckt_count,
  input  logic                  lock,
  input  logic                  external_error,
  output logic                  operation_busy,
  output logic                  operation_complete,
  output logic                  operation_error,
  output logic                  transmission,
  axis_packet_merger_if.slave   s_axis,
  axis_packet_merger_if.master  m_axis
);

  // Payload layout: {tlast, tuser, tdest, tid, tkeep, tdata}
  localparam int unsigned KEEP_LO = DATA_WIDTH;
  localparam int unsigned ID_LO   = KEEP_LO + KEEP_WIDTH;
  localparam int unsigned DEST_LO = ID_LO + ID_WIDTH;
  localparam int unsigned USER_LO = DEST_LO + DEST_WIDTH;
  localparam int unsigned LAST_BIT = USER_LO + USER_WIDTH;
  localparam int unsigned PAY_W   = LAST_BIT + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_OPER, ST_END, ST_ERR} state_e;

  state_e                state_q, state_d;
  logic [PCKT_WIDTH-1:0] size_q, size_d, beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d, pkt_cnt_q, pkt_cnt_d;
  logic                  busy_q, busy_d, complete_q, complete_d;
  logic                  error_q, error_d, xmit_q, xmit_d;
  logic [PAY_W-1:0]      out_pay_q, out_pay_d, tmp_pay_q, tmp_pay_d;
  logic                  out_valid_q, out_valid_d, tmp_valid_q, tmp_valid_d;

  logic             lock_c, s_ready_c, accept_c;
  logic             last_beat_c, last_pkt_c, tlast_err_c;
  logic [PAY_W-1:0] in_pay_c;

  assign lock_c      = ALLOW_LOCKS && lock;
  assign s_ready_c   = busy_q && !tmp_valid_q && !lock_c;
  assign accept_c    = s_axis.tvalid && s_ready_c;
  assign last_beat_c = (beat_cnt_q == size_q - PCKT_WIDTH'(1));
  assign last_pkt_c  = (pkt_cnt_q == count_q - CNT_WIDTH'(1));
  assign tlast_err_c = CHECK_TLAST && (s_axis.tlast != last_beat_c);

  // A tlast mismatch closes the output packet on the offending beat.
  assign in_pay_c = {(last_beat_c && last_pkt_c) || tlast_err_c,
                     USER_ENABLE ? s_axis.tuser : USER_WIDTH'(0),
                     DEST_ENABLE ? s_axis.tdest : DEST_WIDTH'(0),
                     ID_ENABLE   ? s_axis.tid   : ID_WIDTH'(0),
                     KEEP_ENABLE ? s_axis.tkeep : {KEEP_WIDTH{1'b1}},
                     s_axis.tdata};

  // Control FSM and beat/packet counters
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    count_d    = count_q;
    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    unique case (state_q)
      ST_IDLE, ST_END: begin
        if (state_q == ST_END) state_d = ST_IDLE;
        // Lock holds IDLE; END is a single-cycle pulse and is never held.
        if (operation_start && !(lock_c && state_q == ST_IDLE)) begin
          size_d     = pckt_size;
          count_d    = pckt_count;
          beat_cnt_d = '0;
          pkt_cnt_d  = '0;
          state_d    = (pckt_size == '0 || pckt_count == '0) ? ST_ERR : ST_OPER;
        end
      end
      ST_OPER: begin
        if (accept_c) begin
          if (tlast_err_c) begin
            state_d = ST_ERR;
          end else if (last_beat_c) begin
            beat_cnt_d = '0;
            pkt_cnt_d  = pkt_cnt_q + CNT_WIDTH'(1);
            if (last_pkt_c) state_d = ST_END;
          end else begin
            beat_cnt_d = beat_cnt_q + PCKT_WIDTH'(1);
          end
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (external_error) state_d = ST_ERR;
    busy_d     = (state_d == ST_OPER);
    complete_d = (state_d == ST_END);
    error_d    = (state_d == ST_ERR);
  end

  // Two-entry skid: output register plus one overflow slot
  always_comb begin
    out_pay_d   = out_pay_q;
    out_valid_d = out_valid_q;
    tmp_pay_d   = tmp_pay_q;
    tmp_valid_d = tmp_valid_q;
    if (accept_c) begin
      if (!out_valid_q || m_axis.tready) begin
        out_pay_d   = in_pay_c;
        out_valid_d = 1'b1;
      end else begin
        tmp_pay_d   = in_pay_c;
        tmp_valid_d = 1'b1;
      end
    end else if (out_valid_q && m_axis.tready) begin
      if (tmp_valid_q) begin
        out_pay_d   = tmp_pay_q;
        tmp_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    xmit_d = out_valid_q && m_axis.tready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      count_q     <= '0;
      beat_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
      error_q     <= 1'b0;
      xmit_q      <= 1'b0;
      out_pay_q   <= '0;
      out_valid_q <= 1'b0;
      tmp_pay_q   <= '0;
      tmp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      count_q     <= count_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      busy_q      <= busy_d;
      complete_q  <= complete_d;
      error_q     <= error_d;
      xmit_q      <= xmit_d;
      out_pay_q   <= out_pay_d;
      out_valid_q <= out_valid_d;
      tmp_pay_q   <= tmp_pay_d;
      tmp_valid_q <= tmp_valid_d;
    end
  end

  assign operation_busy     = busy_q;
  assign operation_complete = complete_q;
  assign operation_error    = error_q;
  assign transmission       = xmit_q;

  assign s_axis.tready = s_ready_c;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_pay_q[DATA_WIDTH-1:0];
  assign m_axis.tkeep  = out_pay_q[ID_LO-1:KEEP_LO];
  assign m_axis.tid    = out_pay_q[DEST_LO-1:ID_LO];
  assign m_axis.tdest  = out_pay_q[USER_LO-1:DEST_LO];
  assign m_axis.tuser  = out_pay_q[LAST_BIT-1:USER_LO];
  assign m_axis.tlast  = out_pay_q[LAST_BIT];

endmodule
